// File: rtl/spi_slave_pico_if.sv
// PicoRV32-style memory bus bundle for spi_slave_pico.
//   master modport: CPU/interconnect side (drives request, receives response)
//   slave  modport: peripheral side (samples request, drives response)
//   addr/wdata/wen/mem_valid : request
//   mem_ready                : OR of other devices' ready (suppresses response)
//   mem_port_ready/rdata     : one-cycle response pulse and read data
interface spi_slave_pico_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_port_ready;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, wen, mem_valid, mem_ready,
    input  mem_port_ready, rdata
  );

  modport slave (
    input  addr, wdata, wen, mem_valid, mem_ready,
    output mem_port_ready, rdata
  );
endinterface

// File: rtl/spi_slave_pico.sv
// SPI responder (mode 0, MSB first) on the PicoRV32 memory bus.
// All SPI pins are oversampled in the clk domain; no SCLK-clocked logic.
//   clk, reset      : system clock, async active-high reset
//   bus (slave)     : DATA at ADDR (wr: tx byte, rd: rx byte), STATUS at ADDR+4
//                     STATUS = {cs_active, overrun, tx_empty, rx_valid}
//   spi_sclk/cs_n/mosi : asynchronous SPI inputs
//   spi_miso, spi_miso_oe : serial out and pad enable (high while selected)
//   irq             : level, mirrors rx_valid
module spi_slave_pico #(
  parameter logic [31:0] ADDR  = 32'h0000_0000,
  parameter int          WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  spi_slave_pico_if.slave    bus,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  output logic               irq
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t             state_q, state_d;
  // [0],[1] synchroniser, [2] previous value for edge detection
  logic [2:0]         sclk_sync_q, sclk_sync_d;
  logic [2:0]         cs_sync_q, cs_sync_d;
  logic [2:0]         mosi_sync_q, mosi_sync_d;
  logic [WIDTH-1:0]   tx_hold_q, tx_hold_d;
  logic               tx_empty_q, tx_empty_d;
  logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               overrun_q, overrun_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               reload_q, reload_d;
  logic               miso_q, miso_d;
  logic               mem_port_ready_q, mem_port_ready_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               sclk_rise, sclk_fall, cs_fall;
  logic               hit_data, hit_stat, accept;
  logic               rd_data, wr_data, rd_stat;
  logic               word_done;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   rx_next;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

  assign hit_data = (bus.addr == ADDR);
  assign hit_stat = (bus.addr == ADDR + 32'd4);
  assign accept   = bus.mem_valid && (hit_data || hit_stat) &&
                    !bus.mem_ready && !mem_port_ready_q;
  assign rd_data  = accept && hit_data && !bus.wen;
  assign wr_data  = accept && hit_data &&  bus.wen;
  assign rd_stat  = accept && hit_stat && !bus.wen;

  // Underrun sends zeros; always decided from pre-write state
  assign load_val = tx_empty_q ? '0 : tx_hold_q;
  assign rx_next  = {rx_shift_q[WIDTH-2:0], mosi_sync_q[1]};

  always_comb begin
    state_d          = state_q;
    sclk_sync_d      = {sclk_sync_q[1:0], spi_sclk};
    cs_sync_d        = {cs_sync_q[1:0], spi_cs_n};
    mosi_sync_d      = {mosi_sync_q[1:0], spi_mosi};
    tx_hold_d        = tx_hold_q;
    tx_empty_d       = tx_empty_q;
    tx_shift_d       = tx_shift_q;
    rx_shift_d       = rx_shift_q;
    rx_data_d        = rx_data_q;
    rx_valid_d       = rx_valid_q;
    overrun_d        = overrun_q;
    bit_cnt_d        = bit_cnt_q;
    reload_d         = reload_q;
    miso_d           = miso_q;
    word_done        = 1'b0;
    mem_port_ready_d = accept;
    rdata_d          = '0;

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = load_val;
        tx_empty_d = 1'b1;
        bit_cnt_d  = '0;
        reload_d   = 1'b0;
        miso_d     = load_val[WIDTH-1];
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (cs_sync_q[1]) begin
          // Deselect: drop any partial word
          state_d   = IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          miso_d    = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_next;
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
              word_done = 1'b1;
              rx_data_d = rx_next;
              bit_cnt_d = '0;
              reload_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              tx_shift_d = load_val;
              tx_empty_d = 1'b1;
              reload_d   = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
          // MISO follows the shifter one cycle later: 4-cycle fall-to-bit
          miso_d = tx_shift_q[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed word wins over a coincident read: read returns old data
    if (word_done) begin
      rx_valid_d = 1'b1;
      overrun_d  = rd_data ? 1'b0 : (overrun_q | rx_valid_q);
    end else if (rd_data) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    // Write lands after any load this cycle, so tx_empty ends up 0
    if (wr_data) begin
      tx_hold_d  = bus.wdata[WIDTH-1:0];
      tx_empty_d = 1'b0;
    end

    if (rd_data) rdata_d = 32'(rx_data_q);
    if (rd_stat) rdata_d = {28'd0, (state_q != IDLE), overrun_q, tx_empty_q, rx_valid_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      sclk_sync_q      <= '0;
      // CS history resets to "low" so a CS already asserted at release
      // produces no falling edge
      cs_sync_q        <= '0;
      mosi_sync_q      <= '0;
      tx_hold_q        <= '0;
      tx_empty_q       <= 1'b1;
      tx_shift_q       <= '0;
      rx_shift_q       <= '0;
      rx_data_q        <= '0;
      rx_valid_q       <= 1'b0;
      overrun_q        <= 1'b0;
      bit_cnt_q        <= '0;
      reload_q         <= 1'b0;
      miso_q           <= 1'b0;
      mem_port_ready_q <= 1'b0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      sclk_sync_q      <= sclk_sync_d;
      cs_sync_q        <= cs_sync_d;
      mosi_sync_q      <= mosi_sync_d;
      tx_hold_q        <= tx_hold_d;
      tx_empty_q       <= tx_empty_d;
      tx_shift_q       <= tx_shift_d;
      rx_shift_q       <= rx_shift_d;
      rx_data_q        <= rx_data_d;
      rx_valid_q       <= rx_valid_d;
      overrun_q        <= overrun_d;
      bit_cnt_q        <= bit_cnt_d;
      reload_q         <= reload_d;
      miso_q           <= miso_d;
      mem_port_ready_q <= mem_port_ready_d;
      rdata_q          <= rdata_d;
    end
  end

  assign bus.mem_port_ready = mem_port_ready_q;
  assign bus.rdata          = rdata_q;
  assign spi_miso           = miso_q;
  assign spi_miso_oe        = (state_q == SHIFT);
  assign irq                = rx_valid_q;

endmodule

// File: doc/spi_slave_pico.md
# spi_slave_pico

SPI peripheral (slave/responder) for the PicoRV32 memory bus: the remote end of the SPI link that the SPI master block drives. It receives MOSI bytes from an external master, returns a CPU-preloaded byte on MISO in the same transfer, and exposes data and status registers at a parameterised bus address. SPI pins are sampled in the system clock domain; no SCLK-clocked logic.

## Interface
- `ADDR`, 32'h0000_0000: base address; must be set at instantiation. DATA register at `ADDR`, STATUS at `ADDR+4`.
- `WIDTH`, 8: SPI word length in bits (4..16).
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `addr`  in  32  bus address.
- `wdata`  in  32  bus write data; low `WIDTH` bits used.
- `wen`  in  1  write strobe, qualified by `mem_valid`.
- `mem_valid`  in  1  bus request.
- `mem_ready`  in  1  OR of other devices' ready; suppresses this block's response.
- `mem_port_ready`  out  1  one-cycle response pulse.
- `rdata`  out  32  read data, valid while `mem_port_ready`=1; zero-extended.
- `spi_sclk`, `spi_cs_n`, `spi_mosi`  in  1 each  asynchronous SPI inputs.
- `spi_miso`  out  1  serial out; `spi_miso_oe`  out  1  high while CS active (pad tristate enable).
- `irq`  out  1  level, equals `rx_valid`.

## Operation
- Inputs pass 2-flop synchronisers, then a third flop for edge detection. SPI mode 0 only (CPOL=0, CPHA=0), MSB first. SCLK high and low phases must each be ≥4 `clk` periods.
- DATA write: `tx_hold` <= `wdata[WIDTH-1:0]`, `tx_empty` <= 0. DATA read: returns `rx_data`, clears `rx_valid`, `overrun`.
- STATUS read: bit0 `rx_valid`, bit1 `tx_empty`, bit2 `overrun`, bit3 `cs_active`, others 0. STATUS write: ignored.
- Access accepted when `mem_valid` && addr hit && !`mem_ready` && !`mem_port_ready`; side effects occur exactly once, on that cycle.
- FSM states:
  - IDLE: CS inactive, `spi_miso_oe`=0. CS falling edge -> LOAD.
  - LOAD (1 cycle): `tx_shift` <= `tx_hold` if !`tx_empty`, else all-zero (underrun); `tx_empty` <= 1; `bit_cnt` <= 0; `spi_miso` <= `tx_shift` MSB -> SHIFT.
  - SHIFT: SCLK rising: `rx_shift` <= {`rx_shift`, mosi}, `bit_cnt`++. When `bit_cnt` reaches `WIDTH`: `rx_data` <= completed word, `rx_valid` <= 1, `overrun` <= 1 if `rx_valid` was already 1; `bit_cnt` <= 0, arm reload. SCLK falling: if reload armed, reload `tx_shift` as in LOAD; otherwise shift left. Drive `spi_miso` from the new MSB. CS rising -> IDLE.
- CS rise mid-word: partial word discarded, no `rx_valid`, `bit_cnt` cleared, `tx_hold` untouched.
- Overrun policy: new word overwrites `rx_data`.
- Simultaneous events:
  - Word completion on the same cycle as a DATA read: `rx_valid` stays 1 with the new data, no overrun; the read returns the old data.
  - DATA write on the same cycle as a LOAD or reload: the load uses the pre-write state. If `tx_hold` was empty, zeros are sent and the write lands with `tx_empty`=0.

## Timing
- Reset values: `mem_port_ready`=0, `rdata`=0, `spi_miso`=0, `spi_miso_oe`=0, `irq`=0. Internal: `tx_empty`=1, `rx_valid`=0, `overrun`=0, FSM=IDLE.
- Bus latency: `mem_port_ready` high 1 cycle after the accepting edge, then low for at least 1 cycle.
- CS fall to MISO valid (`spi_miso_oe`=1, first bit driven): 4 `clk` cycles. The master must wait ≥4 cycles before the first SCLK rise.
- SCLK rise to bit sampled: 3 cycles. SCLK fall to next MISO bit: 4 cycles.
- Last SCLK rise to `rx_valid`/`irq`: 3 cycles.
- CS rise to `spi_miso_oe`=0: 3 cycles.
- Reset asserted mid-transfer: immediate return to reset values. After release, the block waits for a fresh CS falling edge; a CS already low at release is not treated as a start.

## Test plan
- Reset: assert `reset` mid-word -> all outputs 0; STATUS reads 0x2.
- Full duplex: write DATA=0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; DATA read = 0x3C; `irq` falls after the read.
- Underrun: no DATA write, master sends 0x81 -> MISO all 0; `rx_data`=0x81; STATUS=0x3 (CS high).
- Overrun: two words 0x11, 0x22 with no read -> STATUS bit2=1; DATA read = 0x22; STATUS afterwards = 0x2.
- Abort: CS rises after 5 bits -> `rx_valid`=0; the next full word 0x5A is received correctly.
- Bus arbitration: access with `mem_ready`=1 -> no `mem_port_ready`, no side effects. Back-to-back STATUS/DATA reads -> exactly one pulse each.
